hex7seg_capture_x3: RTL and testbench
=====================================

# hex7seg_capture_x3

Receive-side counterpart of the 3-digit multiplexed hex display driver. It samples the shared active-low segment bus and the active-low digit-enable lines, qualifies each digit slot with a stability filter, and decodes each segment pattern back to a hex nibble. Once every digit has been captured, it reassembles the 12-bit value. Used for display loopback checking and for reading values from an externally driven 3-digit display bus into the task machine.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a slot is captured; legal range 2..255.
- SYNC_STAGES, 2: synchronizer depth on `seg` and `en`; legal range ≥2.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- seg  in  8  active-low segment bus: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- en  in  3  active-low digit enables.
  - 3'b011: digit0, value[3:0].
  - 3'b110: digit1, value[7:4].
  - 3'b101: digit2, value[11:8].
  - 3'b111: blank.
- value  out  12  last completely captured frame.
- value_vld  out  1  one-cycle pulse when `value` updates.
- dp  out  3  decimal points of the last frame, per digit, 1=lit.
- pat_err  out  1  one-cycle pulse on an illegal segment pattern or illegal enable code.

## Operation
- Synchronizer: `seg` and `en` each pass through SYNC_STAGES flops. Synchronizer reset value is all-ones (blank, all segments off).
- Stability counter:
  - Cleared whenever the synchronized {en, seg} differs from the previous cycle's value.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture event: occurs on the cycle the counter reaches STABLE_CYCLES-1. There is exactly one capture per stable run; no re-capture until the inputs change.
- On a capture event:
  - en = 3'b111: ignored; no state change.
  - en is one of the three legal digit codes and seg[7:1] matches one of the 16 hex glyphs:
    - Write the nibble and dp (= ~seg[0]) into that digit slot.
    - Set the slot's `seen` bit.
    - A repeated slot overwrites its previous nibble.
  - Any other en code (000, 001, 010, 100), or a seg[7:1] glyph not in the table (including all-off): pulse `pat_err` and clear all `seen` bits. Slot contents are don't-care.
- Frame completion: when all three `seen` bits are set, on the following cycle:
  - Copy the slots to `value`/`dp`.
  - Pulse `value_vld`.
  - Clear `seen`.
- Glyph table, seg[7:1] for 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001101, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.

## Timing
- Reset (rst_n low at a clk edge):
  - value=0, dp=0, value_vld=0, pat_err=0.
  - seen=0, counter=0, slots=0.
- Input-to-capture latency: SYNC_STAGES + STABLE_CYCLES-1 cycles after the bus settles.
- Capture-to-`value_vld` latency: 1 cycle after the third distinct slot is captured.
- `pat_err` asserts in the capture-event cycle + 1, for exactly one cycle.
- Glitches shorter than STABLE_CYCLES synchronized cycles have no effect.
- Simultaneous frame completion and new capture event: completion takes priority. The new capture is applied to the freshly cleared `seen` in the same cycle.
- Reset mid-frame discards partial slots. No `value_vld` is generated from pre-reset captures.
- `value` holds between frames. Identical consecutive frames still pulse `value_vld`.

## Structure
- Shared package `hex7seg_pkg`, also imported by the display driver:
  - 16-entry glyph constant array.
  - Digit-enable codes: EN_D0=3'b011, EN_D1=3'b110, EN_D2=3'b101, EN_BLANK=3'b111.
- Sub-module `seg7_decode`: combinational; seg[7:1] → nibble[3:0] + hit.
- Top level contains the synchronizer, stability counter, slot registers and frame logic.

## Test plan
- Reset, then drive a stable frame of en=011/seg=0x03 ("0"), en=110/0x01 ("8"), en=101/0x9F ("1"), each held 40 cycles → value=12'h180, one value_vld pulse, dp=3'b000.
- Same frame with digit1 seg=0x00 (dp lit) → value=12'h180, dp=3'b010.
- Insert 5-cycle glitches of seg=0x11 between digits with STABLE_CYCLES=16 → no capture from glitches, value unchanged from the true frame.
- en=3'b001 held 40 cycles mid-frame → pat_err one pulse, seen cleared, no value_vld until three new slots are captured.
- seg=0xFF on digit0 → pat_err; a following full valid frame 0xFA2 → value=12'hFA2.
- Capture two digits, assert rst_n low for 1 cycle, capture only the third digit → no value_vld, value=0.

Source files
------------

// File: rtl/hex7seg_pkg.sv
// Shared definitions for the 3-digit multiplexed hex display: glyph table and digit-enable codes.
package hex7seg_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [2:0] EN_D0    = 3'b011;
  localparam logic [2:0] EN_D1    = 3'b110;
  localparam logic [2:0] EN_D2    = 3'b101;
  localparam logic [2:0] EN_BLANK = 3'b111;

  // Active-low segments a..g (seg[7:1]) for hex digits 0..F.
  localparam logic [6:0] GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // One-hot digit slot for a legal digit-enable code, zero otherwise.
  function automatic logic [NUM_DIGITS-1:0] en_to_slot(input logic [2:0] en);
    case (en)
      EN_D0:   return 3'b001;
      EN_D1:   return 3'b010;
      EN_D2:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/hex7seg_capture_x3_decode.sv
// Combinational reverse lookup of a 7-segment glyph to its hex nibble.
module seg7_decode
  import hex7seg_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (glyph == GLYPHS[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex7seg_capture_x3.sv
// Captures a multiplexed 3-digit active-low 7-segment display bus and rebuilds the 12-bit value.
module hex7seg_capture_x3
  import hex7seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [2:0]  en,
  output logic [11:0] value,
  output logic        value_vld,
  output logic [2:0]  dp,
  output logic        pat_err
);

  logic [7:0]            seg_sync [SYNC_STAGES];
  logic [2:0]            en_sync  [SYNC_STAGES];
  logic [10:0]           bus_p0;
  logic [10:0]           bus_p1;
  logic [7:0]            cnt_p1;
  logic                  stable_p0;
  logic                  vld_p1;
  logic [3:0]            nib_p1;
  logic                  hit_p1;
  logic [NUM_DIGITS-1:0] slot_oh_p1;
  logic                  blank_p1;
  logic                  cap_ok_p1;
  logic                  cap_err_p1;
  logic [NUM_DIGITS-1:0] seen_q;
  logic [NUM_DIGITS-1:0] seen_nx;
  logic                  frame_done;
  logic [3:0]            nib_q [NUM_DIGITS];
  logic                  dp_q  [NUM_DIGITS];

  // ---- stage p0: synchronizers, reset to the blank bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= '1;
        en_sync[i]  <= '1;
      end
    end else begin
      seg_sync[0] <= seg;
      en_sync[0]  <= en;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= seg_sync[i-1];
        en_sync[i]  <= en_sync[i-1];
      end
    end
  end

  assign bus_p0    = {en_sync[SYNC_STAGES-1], seg_sync[SYNC_STAGES-1]};
  assign stable_p0 = (bus_p0 == bus_p1);

  // ---- stage p1: held bus value and how long it has been stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_p1 <= '1;
      cnt_p1 <= '0;
    end else begin
      bus_p1 <= bus_p0;
      if (!stable_p0)
        cnt_p1 <= '0;
      else if (cnt_p1 != 8'(STABLE_CYCLES))
        cnt_p1 <= cnt_p1 + 8'd1;
    end
  end

  // The count passes STABLE_CYCLES-1 exactly once per run, giving one capture per stable level.
  assign vld_p1 = (cnt_p1 == 8'(STABLE_CYCLES - 1));

  seg7_decode u_decode (
    .glyph  (bus_p1[7:1]),
    .nibble (nib_p1),
    .hit    (hit_p1)
  );

  assign slot_oh_p1 = en_to_slot(bus_p1[10:8]);
  assign blank_p1   = (bus_p1[10:8] == EN_BLANK);
  assign cap_ok_p1  = vld_p1 && (slot_oh_p1 != '0) && hit_p1;
  assign cap_err_p1 = vld_p1 && !blank_p1 && !((slot_oh_p1 != '0) && hit_p1);
  assign frame_done = &seen_q;

  // Completion clears seen first so a coincident capture lands in the new frame.
  always_comb begin
    seen_nx = frame_done ? '0 : seen_q;
    if (cap_err_p1)
      seen_nx = '0;
    else if (cap_ok_p1)
      seen_nx = seen_nx | slot_oh_p1;
  end

  // ---- stage p2: slot registers and frame output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q    <= '0;
      value     <= '0;
      dp        <= '0;
      value_vld <= 1'b0;
      pat_err   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        nib_q[i] <= '0;
        dp_q[i]  <= 1'b0;
      end
    end else begin
      seen_q    <= seen_nx;
      value_vld <= frame_done;
      pat_err   <= cap_err_p1;
      if (frame_done) begin
        value <= {nib_q[2], nib_q[1], nib_q[0]};
        dp    <= {dp_q[2], dp_q[1], dp_q[0]};
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_ok_p1 && slot_oh_p1[i]) begin
          nib_q[i] <= nib_p1;
          dp_q[i]  <= ~bus_p1[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_hex7seg_capture_x3.sv
// Directed bench for hex7seg_capture_x3: frames, dp, glitches, pattern errors and mid-frame reset.
module tb_hex7seg_capture_x3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg;
  logic [2:0]  en;
  logic [11:0] value;
  logic        value_vld;
  logic [2:0]  dp;
  logic        pat_err;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  int perr_cnt = 0;
  int vld_ref;
  int perr_ref;

  hex7seg_capture_x3 #(.STABLE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .en        (en),
    .value     (value),
    .value_vld (value_vld),
    .dp        (dp),
    .pat_err   (pat_err)
  );

  always #5 clk = ~clk;

  // Count output pulses in active cycles, sampled on the falling edge.
  always @(negedge clk) begin
    if (value_vld) vld_cnt++;
    if (pat_err)   perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [2:0] e, input logic [7:0] s, input int n);
    en  = e;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 3'b111;
    seg   = 8'hFF;
    repeat (4) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_vld", 32'(value_vld), 32'h0);
    check("rst_perr", 32'(pat_err), 32'h0);
    rst_n = 1'b1;
    hold(3'b111, 8'hFF, 10);

    // Frame "180", no dp
    hold(3'b011, 8'h03, 40);
    hold(3'b110, 8'h01, 40);
    hold(3'b101, 8'h9F, 40);
    hold(3'b111, 8'hFF, 40);
    check("f1_vld_cnt", 32'(vld_cnt), 32'd1);
    check("f1_value", 32'(value), 32'h180);
    check("f1_dp", 32'(dp), 32'h0);
    check("f1_perr", 32'(perr_cnt), 32'd0);

    // Same frame with digit1 decimal point lit
    hold(3'b011, 8'h03, 40);
    hold(3'b110, 8'h00, 40);
    hold(3'b101, 8'h9F, 40);
    hold(3'b111, 8'hFF, 40);
    check("f2_vld_cnt", 32'(vld_cnt), 32'd2);
    check("f2_value", 32'(value), 32'h180);
    check("f2_dp", 32'(dp), 32'h2);

    // Short "A" glitches on digit0 must not be captured
    hold(3'b011, 8'h03, 40);
    hold(3'b011, 8'h11, 5);
    hold(3'b110, 8'h01, 40);
    hold(3'b011, 8'h11, 5);
    hold(3'b101, 8'h9F, 40);
    hold(3'b111, 8'hFF, 40);
    check("gl_vld_cnt", 32'(vld_cnt), 32'd3);
    check("gl_value", 32'(value), 32'h180);
    check("gl_dp", 32'(dp), 32'h0);
    check("gl_perr", 32'(perr_cnt), 32'd0);

    // Illegal enable mid-frame clears seen
    hold(3'b011, 8'h03, 40);
    hold(3'b110, 8'h01, 40);
    hold(3'b001, 8'h03, 40);
    hold(3'b111, 8'hFF, 20);
    check("en_err_perr", 32'(perr_cnt), 32'd1);
    check("en_err_no_vld", 32'(vld_cnt), 32'd3);
    hold(3'b101, 8'h49, 40);
    hold(3'b111, 8'hFF, 20);
    check("en_err_one_slot", 32'(vld_cnt), 32'd3);
    hold(3'b011, 8'h1B, 40);
    hold(3'b110, 8'h11, 40);
    hold(3'b111, 8'hFF, 40);
    check("en_err_new_vld", 32'(vld_cnt), 32'd4);
    check("en_err_value", 32'(value), 32'h5A7);

    // All-off glyph on digit0, then frame FA2
    hold(3'b011, 8'hFF, 40);
    hold(3'b111, 8'hFF, 20);
    check("blank_glyph_perr", 32'(perr_cnt), 32'd2);
    hold(3'b101, 8'h71, 40);
    hold(3'b110, 8'h11, 40);
    hold(3'b011, 8'h25, 40);
    hold(3'b111, 8'hFF, 40);
    check("fa2_vld_cnt", 32'(vld_cnt), 32'd5);
    check("fa2_value", 32'(value), 32'hFA2);
    check("fa2_perr", 32'(perr_cnt), 32'd2);

    // Reset after two digits; third digit alone must not complete a frame
    hold(3'b011, 8'h03, 40);
    hold(3'b110, 8'h01, 40);
    vld_ref  = vld_cnt;
    perr_ref = perr_cnt;
    en    = 3'b101;
    seg   = 8'h9F;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(3'b101, 8'h9F, 40);
    hold(3'b111, 8'hFF, 40);
    check("rst_mid_no_vld", 32'(vld_cnt), 32'(vld_ref));
    check("rst_mid_value", 32'(value), 32'h0);
    check("rst_mid_dp", 32'(dp), 32'h0);
    check("rst_mid_perr", 32'(perr_cnt), 32'(perr_ref));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
